// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: fetch queue entry and fetch FSM states.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, inst} pairs with push/pop/flush.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_pc,
  input  logic [WIDTH-1:0]         push_inst,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_pc,
  output logic [WIDTH-1:0]         head_inst
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] pc_q   [DEPTH];
  logic [WIDTH-1:0] inst_q [DEPTH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; empty head reads are masked below.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_q[tail_q]   <= push_pc;
      inst_q[tail_q] <= push_inst;
    end
  end

  assign count     = count_q;
  assign head_pc   = (count_q == '0) ? '0 : pc_q[head_q];
  assign head_inst = (count_q == '0) ? '0 : inst_q[head_q];

endmodule

// File: rtl/fetch_queue.sv
// Run-ahead instruction fetch: sequential requests into a small queue,
// flushed by redirect with stale in-flight responses discarded.
module fetch_queue
  import rv32i_types::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0060)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   inst_read,
  output logic [WIDTH-1:0]       inst_addr,
  input  logic                   inst_resp,
  input  logic [WIDTH-1:0]       inst_rdata,
  input  logic                   redirect,
  input  logic [WIDTH-1:0]       redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_inst,
  output logic [WIDTH-1:0]       out_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int               CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]      DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(4);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0] target;
  logic [CW-1:0]    count;
  logic [CW:0]      occ_pop, occ_push;
  logic             push, pop;

  assign target    = {redirect_pc[WIDTH-1:2], 2'b00};
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready && !redirect;
  assign push      = (state_q == REQ) && inst_resp && !redirect;
  assign occ_pop   = {1'b0, count} - (CW+1)'(pop);
  assign occ_push  = occ_pop + (CW+1)'(push);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      IDLE: begin
        // Redirect empties the queue, so a slot is guaranteed free.
        if (redirect) begin
          fetch_pc_d = target;
          req_addr_d = target;
          state_d    = REQ;
        end else if (occ_pop < DEPTH_W) begin
          req_addr_d = fetch_pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (inst_resp && redirect) begin
          fetch_pc_d = target;
          req_addr_d = target;
        end else if (redirect) begin
          fetch_pc_d = target;
          state_d    = DRAIN;
        end else if (inst_resp) begin
          fetch_pc_d = req_addr_q + STEP;
          if (occ_push < DEPTH_W) req_addr_d = req_addr_q + STEP;
          else                    state_d    = IDLE;
        end
      end
      DRAIN: begin
        if (redirect) fetch_pc_d = target;
        if (inst_resp) begin
          req_addr_d = redirect ? target : fetch_pc_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (req_addr_q),
    .push_inst (inst_rdata),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head_pc   (out_pc),
    .head_inst (out_inst)
  );

  assign inst_read = (state_q == REQ) || (state_q == DRAIN);
  assign inst_addr = req_addr_q;
  assign occupancy = count;

endmodule
